imem_boot_loader: RTL and testbench

- Boot-time loader sitting directly upstream of the single-cycle MIPS core.
- Receives a byte stream over a valid/ready interface, assembles 32-bit instruction words and writes them into instruction memory through a write port.
- Holds the core in reset until a complete, valid image has been written, then releases it.

---
 rtl/boot_loader_pkg.sv | 20 ++
 rtl/word_assembler.sv | 42 ++++
 rtl/imem_boot_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// default start-of-image byte and the image byte-order constants.
package boot_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CHK,
      DONE,
      ERR
   } boot_state_e;

   localparam logic [7:0]  DEFAULT_MAGIC  = 8'hA5;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam bit          LEN_MSB_FIRST  = 1'b1;
   localparam bit          WORD_MSB_FIRST = 1'b1;

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes into 32-bit words; word_valid_o and word_o are
// combinational on the accept of the last byte so the caller can register them.
module word_assembler
   import boot_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        take_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam int CNT_W = $clog2(BYTES_PER_WORD);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [23:0]      shift_q, shift_d;

   // Only the first three bytes are stored; the fourth is merged on the fly.
   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (take_i) begin
         cnt_d   = cnt_q + CNT_W'(1);
         shift_d = WORD_MSB_FIRST ? {shift_q[15:0], byte_i} : {byte_i, shift_q[23:8]};
      end
   end

   assign word_valid_o = take_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
   assign word_o       = WORD_MSB_FIRST ? {shift_q, byte_i} : {byte_i, shift_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses MAGIC/length/words from a byte stream, writes imem and
// releases the core. Define BOOT_CHECKSUM_EN to require a trailing XOR byte.
module imem_boot_loader
   import boot_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter logic [7:0]  MAGIC  = DEFAULT_MAGIC
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              boot_done,
   output logic              boot_err
);

`ifdef BOOT_CHECKSUM_EN
   localparam boot_state_e AFTER_DATA = CHK;
`else
   localparam boot_state_e AFTER_DATA = DONE;
`endif
   localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

   boot_state_e       state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [31:0]       len_full;
   logic [ADDR_W-1:0] idx_q, idx_d;

   logic              rx_ready_q;
   logic              imem_we_q;
   logic [ADDR_W-1:0] imem_addr_q;
   logic [31:0]       imem_wdata_q;
   logic              boot_done_q;
   logic              boot_err_q;
   logic              cpu_rst_n_q;

   logic              accept;
   logic              take;
   logic              word_valid;
   logic [31:0]       asm_word;

   assign accept = rx_valid && rx_ready_q;
   assign take   = accept && (state_q == DATA);

   word_assembler u_word_assembler (
      .clk          (clk),
      .rst_n        (rst_n),
      .take_i       (take),
      .byte_i       (rx_data),
      .word_valid_o (word_valid),
      .word_o       (asm_word)
   );

`ifdef BOOT_CHECKSUM_EN
   logic [7:0] chk_q, chk_d;

   always_comb begin
      chk_d = chk_q;
      if (accept && (state_q == LEN_HI || state_q == LEN_LO || state_q == DATA)) begin
         chk_d = chk_q ^ rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_q <= '0;
      end else begin
         chk_q <= chk_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      idx_d    = idx_q;
      len_full = {16'd0, len_q};
      unique case (state_q)
         IDLE: begin
            if (accept && rx_data == MAGIC) state_d = LEN_HI;
         end
         LEN_HI: begin
            if (accept) begin
               if (LEN_MSB_FIRST) len_d[15:8] = rx_data;
               else               len_d[7:0]  = rx_data;
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (accept) begin
               if (LEN_MSB_FIRST) len_d[7:0]  = rx_data;
               else               len_d[15:8] = rx_data;
               len_full = {16'd0, len_d};
               // Oversize images are refused before any write so idx never wraps.
               if (len_full > DEPTH)      state_d = ERR;
               else if (len_full == '0)   state_d = AFTER_DATA;
               else                       state_d = DATA;
            end
         end
         DATA: begin
            if (word_valid) begin
               if (32'(idx_q) + 32'd1 == len_full) state_d = AFTER_DATA;
               else                                idx_d   = idx_q + ADDR_W'(1);
            end
         end
         CHK: begin
`ifdef BOOT_CHECKSUM_EN
            if (accept) state_d = (rx_data == chk_q) ? DONE : ERR;
`endif
         end
         DONE, ERR: begin
         end
         default: state_d = IDLE;
      endcase
   end

   // cpu_rst_n trails boot_done by one edge so the last write retires first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         idx_q        <= '0;
         rx_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         boot_done_q  <= 1'b0;
         boot_err_q   <= 1'b0;
         cpu_rst_n_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         rx_ready_q   <= !(state_d == DONE || state_d == ERR);
         imem_we_q    <= word_valid;
         if (word_valid) begin
            imem_addr_q  <= idx_q;
            imem_wdata_q <= asm_word;
         end
         boot_done_q  <= (state_d == DONE);
         boot_err_q   <= (state_d == ERR);
         cpu_rst_n_q  <= boot_done_q;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign boot_done  = boot_done_q;
   assign boot_err   = boot_err_q;
   assign cpu_rst_n  = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: an image-queue model checked every
// cycle, plus literal expectations for the directed images.
module tb_imem_boot_loader;

`ifdef BOOT_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int         DEPTH = 256;
   localparam logic [7:0] MAGIC = 8'hA5;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        rxValid = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic        rxReady;
   logic        imemWe;
   logic [7:0]  imemAddr;
   logic [31:0] imemWdata;
   logic        cpuRstN;
   logic        bootDone;
   logic        bootErr;

   int checks = 0;
   int errors = 0;
   bit cmpOn = 1'b0;

   imem_boot_loader #(.ADDR_W(8), .MAGIC(MAGIC)) dut (
      .clk        (clk),
      .rst_n      (rstN),
      .rx_valid   (rxValid),
      .rx_data    (rxData),
      .rx_ready   (rxReady),
      .imem_we    (imemWe),
      .imem_addr  (imemAddr),
      .imem_wdata (imemWdata),
      .cpu_rst_n  (cpuRstN),
      .boot_done  (bootDone),
      .boot_err   (bootErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every byte accepted after MAGIC is kept; outputs follow from the image so far.
   logic [7:0]  img[$];
   logic        mReady = 0, mWe = 0, mDone = 0, mErr = 0, mCpu = 0;
   logic [7:0]  mAddr = 0;
   logic [31:0] mWdata = 0;
   int          mSz, mN, mK;
   logic [7:0]  mX;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         img.delete();
         mReady = 0; mWe = 0; mDone = 0; mErr = 0; mCpu = 0; mAddr = 0; mWdata = 0;
      end else begin
         mCpu = mDone;
         mWe  = 0;
         if (rxValid && mReady) begin
            if (img.size() == 0) begin
               if (rxData == MAGIC) img.push_back(rxData);
            end else begin
               img.push_back(rxData);
               mSz = img.size();
               if (mSz >= 3) mN = int'({img[1], img[2]});
               if (mSz == 3) begin
                  if (mN > DEPTH)              mErr  = 1;
                  else if (mN == 0 && !CHK_EN) mDone = 1;
               end else if (mSz > 3 && mSz <= 3 + 4 * mN) begin
                  if ((mSz - 3) % 4 == 0) begin
                     mK     = (mSz - 3) / 4 - 1;
                     mWe    = 1;
                     mAddr  = 8'(mK);
                     mWdata = {img[mSz-4], img[mSz-3], img[mSz-2], img[mSz-1]};
                  end
                  if (mSz == 3 + 4 * mN && !CHK_EN) mDone = 1;
               end else if (mSz > 3) begin
                  mX = 8'h00;
                  for (int i = 1; i < mSz - 1; i++) mX = mX ^ img[i];
                  if (mX == rxData) mDone = 1;
                  else              mErr  = 1;
               end
            end
         end
         mReady = !(mDone || mErr);
      end
   end

   always @(negedge clk) begin
      if (cmpOn) begin
         checkOutput("rx_ready",   {31'd0, rxReady},  {31'd0, mReady});
         checkOutput("imem_we",    {31'd0, imemWe},   {31'd0, mWe});
         checkOutput("imem_addr",  {24'd0, imemAddr}, {24'd0, mAddr});
         checkOutput("imem_wdata", imemWdata,         mWdata);
         checkOutput("boot_done",  {31'd0, bootDone}, {31'd0, mDone});
         checkOutput("boot_err",   {31'd0, bootErr},  {31'd0, mErr});
         checkOutput("cpu_rst_n",  {31'd0, cpuRstN},  {31'd0, mCpu});
      end
   end

   // Write log and edge timestamps used by the literal expectations.
   int          cycle = 0;
   logic [7:0]  wrAddr[$];
   logic [31:0] wrData[$];
   int          lastWeCycle = -1, doneRiseCycle = -1, cpuRiseCycle = -1;
   logic        prevDone = 0, prevCpu = 0;

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (imemWe === 1'b1) begin
         wrAddr.push_back(imemAddr);
         wrData.push_back(imemWdata);
         lastWeCycle = cycle;
      end
      if (bootDone === 1'b1 && !prevDone) doneRiseCycle = cycle;
      if (cpuRstN === 1'b1 && !prevCpu)   cpuRiseCycle  = cycle;
      prevDone = bootDone;
      prevCpu  = cpuRstN;
   end

   logic [7:0] txQ[$];

   task automatic clearLog();
      wrAddr.delete();
      wrData.delete();
      lastWeCycle = -1; doneRiseCycle = -1; cpuRiseCycle = -1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".rx_ready"},   {31'd0, rxReady},  32'd0);
      checkOutput({tag, ".imem_we"},    {31'd0, imemWe},   32'd0);
      checkOutput({tag, ".imem_addr"},  {24'd0, imemAddr}, 32'd0);
      checkOutput({tag, ".imem_wdata"}, imemWdata,         32'd0);
      checkOutput({tag, ".cpu_rst_n"},  {31'd0, cpuRstN},  32'd0);
      checkOutput({tag, ".boot_done"},  {31'd0, bootDone}, 32'd0);
      checkOutput({tag, ".boot_err"},   {31'd0, bootErr},  32'd0);
   endtask

   task automatic doReset();
      rxValid = 1'b0;
      rstN    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      clearLog();
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gap);
      int  waited;
      logic rdy;
      waited  = 0;
      rxValid = 1'b1;
      rxData  = b;
      forever begin
         @(negedge clk);
         rdy = rxReady;
         @(posedge clk);
         #1;
         if (rdy === 1'b1) break;
         waited++;
         if (waited > 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: byte 0x%0h not taken after %0d cycles, expected rx_ready=1", b, waited);
            break;
         end
      end
      rxValid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendTx(input int gap);
      foreach (txQ[i]) applyStimulus(txQ[i], gap);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic loadNominal(input logic [7:0] chkByte);
      txQ = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h09, 8'h00, 8'h00};
      if (CHK_EN) txQ.push_back(chkByte);
   endtask

   task automatic checkNominal(input string tag);
      checkOutput({tag, ".writes"}, wrAddr.size(), 32'd2);
      if (wrAddr.size() >= 2) begin
         checkOutput({tag, ".addr0"}, {24'd0, wrAddr[0]}, 32'd0);
         checkOutput({tag, ".data0"}, wrData[0],          32'h20080005);
         checkOutput({tag, ".addr1"}, {24'd0, wrAddr[1]}, 32'd1);
         checkOutput({tag, ".data1"}, wrData[1],          32'hAC090000);
      end
      checkOutput({tag, ".boot_done"},  {31'd0, bootDone}, 32'd1);
      checkOutput({tag, ".cpu_rst_n"},  {31'd0, cpuRstN},  32'd1);
      checkOutput({tag, ".cpu_delay"},  cpuRiseCycle - doneRiseCycle, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] x;
      @(posedge clk);
      cmpOn = 1'b1;
      doReset();

      $display("[TB] nominal load");
      loadNominal(8'h8A);
      sendTx(0);
      checkNominal("nominal");

`ifdef BOOT_CHECKSUM_EN
      $display("[TB] checksum mismatch");
      doReset();
      loadNominal(8'h00);
      sendTx(0);
      checkOutput("badchk.boot_done", {31'd0, bootDone}, 32'd0);
      checkOutput("badchk.boot_err",  {31'd0, bootErr},  32'd1);
      checkOutput("badchk.cpu_rst_n", {31'd0, cpuRstN},  32'd0);
      checkOutput("badchk.rx_ready",  {31'd0, rxReady},  32'd0);
`endif

      $display("[TB] junk then stalled stream");
      doReset();
      txQ = '{8'h00, 8'hFF, 8'h3C};
      sendTx(1);
      loadNominal(8'h8A);
      sendTx(1);
      checkNominal("stalled");

      $display("[TB] oversize length");
      doReset();
      txQ = '{8'hA5, 8'h01, 8'h01};
      sendTx(0);
      checkOutput("oversize.boot_err",  {31'd0, bootErr},  32'd1);
      checkOutput("oversize.writes",    wrAddr.size(),     32'd0);
      checkOutput("oversize.rx_ready",  {31'd0, rxReady},  32'd0);
      checkOutput("oversize.cpu_rst_n", {31'd0, cpuRstN},  32'd0);

      $display("[TB] reset mid-image");
      doReset();
      loadNominal(8'h8A);
      for (int i = 0; i < 6; i++) applyStimulus(txQ[i], 0);
      rstN = 1'b0;
      #2;
      checkResetOutputs("midreset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      clearLog();
      sendTx(0);
      checkNominal("reload");

      $display("[TB] single-word image");
      doReset();
      txQ = '{8'hA5, 8'h00, 8'h01, 8'h24, 8'h02, 8'h00, 8'h07};
      if (CHK_EN) txQ.push_back(8'h20);
      sendTx(0);
      checkOutput("single.writes", wrAddr.size(), 32'd1);
      if (wrAddr.size() >= 1) begin
         checkOutput("single.addr0", {24'd0, wrAddr[0]}, 32'd0);
         checkOutput("single.data0", wrData[0],          32'h24020007);
      end
      checkOutput("single.boot_done", {31'd0, bootDone}, 32'd1);
      checkOutput("single.cpu_after_we", cpuRiseCycle - lastWeCycle, CHK_EN ? 32'd2 : 32'd1);

      $display("[TB] zero-length image");
      doReset();
      txQ = '{8'hA5, 8'h00, 8'h00};
      if (CHK_EN) txQ.push_back(8'h00);
      sendTx(0);
      checkOutput("empty.writes",    wrAddr.size(),     32'd0);
      checkOutput("empty.boot_done", {31'd0, bootDone}, 32'd1);
      checkOutput("empty.boot_err",  {31'd0, bootErr},  32'd0);

      $display("[TB] full-depth image");
      doReset();
      txQ = '{8'hA5, 8'h01, 8'h00};
      for (int i = 0; i < DEPTH; i++) begin
         txQ.push_back(8'(i));
         txQ.push_back(8'hC3);
         txQ.push_back(8'(255 - i));
         txQ.push_back(8'h3C);
      end
      x = 8'h00;
      for (int i = 1; i < txQ.size(); i++) x = x ^ txQ[i];
      if (CHK_EN) txQ.push_back(x);
      sendTx(0);
      checkOutput("full.writes", wrAddr.size(), 32'd256);
      if (wrAddr.size() == 256) begin
         checkOutput("full.addr255", {24'd0, wrAddr[255]}, 32'd255);
         checkOutput("full.data255", wrData[255],          32'hFFC3003C);
      end
      checkOutput("full.boot_done", {31'd0, bootDone}, 32'd1);

      cmpOn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
